fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the PC and runs a request/ready handshake with a variable-latency instruction memory. It presents {pc_o, inst_o, valid_o} to IF/ID, which latches them every cycle. It honours hazard stalls, and branch redirects from ID by dropping wrong-path fetches.

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency
// instruction memory through a req/ready handshake, and feeds the IF/ID
// register with {pc_o, inst_o, valid_o}. Handles hazard stalls and drops
// wrong-path fetches after a branch redirect from ID.
//
// Handshake: imem_req_o is a request valid. While imem_req_o=1 and
// imem_ready_i=0, imem_addr_o is held stable. A transfer completes on a
// rising clk_i edge where imem_req_o=1 and imem_ready_i=1; imem_data_i is
// only looked at in that cycle.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic [1:0]  fsm_state
);

    // FETCH: request outstanding for addr_q, its data is wanted.
    // DROP:  request outstanding but wrong path; its data is discarded.
    // HOLD:  an instruction was received under stall and is parked.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] redirect_q;
    logic [31:0] hold_inst_q;
    logic [31:0] hold_pc_q;
    logic [31:0] addr_next_seq;

    // Sequential successor of the outstanding address, wraps modulo 2^32.
    assign addr_next_seq = addr_q + PC_STEP;

    // Request is suppressed while reset is held and while parked in HOLD.
    assign imem_req_o  = rst_i && (state != HOLD);
    assign imem_addr_o = addr_q;
    assign fsm_state   = state;

    // Fetch control FSM with registered IF/ID outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= FETCH;
            addr_q      <= RESET_PC;
            redirect_q  <= 32'h0;
            hold_inst_q <= 32'h0;
            hold_pc_q   <= 32'h0;
            pc_o        <= 32'h0;
            inst_o      <= 32'h0;
            valid_o     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready_i) begin
                        if (branch_i) begin
                            // Fetched word is on the wrong path: discard.
                            addr_q  <= branch_target_i;
                            inst_o  <= 32'h0;
                            valid_o <= 1'b0;
                        end else if (!stall_i) begin
                            inst_o  <= imem_data_i;
                            pc_o    <= addr_next_seq;
                            valid_o <= 1'b1;
                            addr_q  <= addr_next_seq;
                        end else begin
                            // ID is stalled: park the word, keep outputs.
                            hold_inst_q <= imem_data_i;
                            hold_pc_q   <= addr_next_seq;
                            addr_q      <= addr_next_seq;
                            state       <= HOLD;
                        end
                    end else begin
                        if (branch_i) begin
                            // Cannot retarget mid-request; remember target.
                            redirect_q <= branch_target_i;
                            inst_o     <= 32'h0;
                            valid_o    <= 1'b0;
                            state      <= DROP;
                        end else if (!stall_i) begin
                            inst_o  <= 32'h0;
                            valid_o <= 1'b0;
                        end
                    end
                end

                DROP: begin
                    inst_o  <= 32'h0;
                    valid_o <= 1'b0;
                    if (branch_i) begin
                        redirect_q <= branch_target_i;
                    end
                    if (imem_ready_i) begin
                        // Newest target wins, including one arriving now.
                        addr_q <= branch_i ? branch_target_i : redirect_q;
                        state  <= FETCH;
                    end
                end

                HOLD: begin
                    if (branch_i) begin
                        addr_q  <= branch_target_i;
                        inst_o  <= 32'h0;
                        valid_o <= 1'b0;
                        state   <= FETCH;
                    end else if (!stall_i) begin
                        inst_o  <= hold_inst_q;
                        pc_o    <= hold_pc_q;
                        valid_o <= 1'b1;
                        state   <= FETCH;
                    end
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The instruction memory returns
// addr ^ 32'hA5A5_0000; ready is driven per cycle by the stimulus.
module tb_fetch_stage;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic [1:0]  fsm_state;

    int total;
    int bad;

    // clock / reset block
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .branch_i       (branch_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ready_i   (imem_ready_i),
        .imem_data_i    (imem_data_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .valid_o        (valid_o),
        .fsm_state      (fsm_state)
    );

    // memory model
    assign imem_data_i = imem_addr_o ^ 32'hA5A5_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // advance one edge, settle outputs
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt);
        imem_ready_i    = rdy;
        stall_i         = stl;
        branch_i        = br;
        branch_target_i = tgt;
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic vld);
        check({tag, ".pc"},    pc_o,            pc);
        check({tag, ".inst"},  inst_o,          inst);
        check({tag, ".valid"}, {31'h0, valid_o}, {31'h0, vld});
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".req"},  {31'h0, imem_req_o}, {31'h0, req});
        check({tag, ".addr"}, imem_addr_o,         addr);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // reset state
        step();
        step();
        check_out("rst", 32'h0, 32'h0, 1'b0);
        check("rst.req", {31'h0, imem_req_o}, 32'h0);
        rst_i = 1'b1;
        #1;
        check_req("rel", 1'b1, 32'h0);

        // zero-wait stream
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_out("zw0", 32'h4, 32'hA5A5_0000, 1'b1);
        step();
        check_out("zw1", 32'h8, 32'hA5A5_0004, 1'b1);
        step();
        check_out("zw2", 32'hC, 32'hA5A5_0008, 1'b1);
        check_req("zw2", 1'b1, 32'hC);

        // two wait cycles at 0xC
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_out("w0", 32'hC, 32'h0, 1'b0);
        check_req("w0", 1'b1, 32'hC);
        step();
        check_out("w1", 32'hC, 32'h0, 1'b0);
        check_req("w1", 1'b1, 32'hC);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_out("w2", 32'h10, 32'hA5A5_000C, 1'b1);
        check_req("w2", 1'b1, 32'h10);

        // stall arriving with ready for 0x10, held 3 cycles
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check_out("st0", 32'h10, 32'hA5A5_000C, 1'b1);
        check_req("st0", 1'b0, 32'h14);
        check("st0.state", {30'h0, fsm_state}, 32'd2);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        check_out("st1", 32'h10, 32'hA5A5_000C, 1'b1);
        step();
        check_out("st2", 32'h10, 32'hA5A5_000C, 1'b1);
        check("st2.req", {31'h0, imem_req_o}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_out("st3", 32'h14, 32'hA5A5_0010, 1'b1);
        check_req("st3", 1'b1, 32'h14);

        // branch to 0x100 while 0x14 waits
        drive(1'b0, 1'b0, 1'b1, 32'h100);
        step();
        check_out("br0", 32'h14, 32'h0, 1'b0);
        check("br0.state", {30'h0, fsm_state}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_out("br1", 32'h14, 32'h0, 1'b0);
        check_req("br1", 1'b1, 32'h14);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_out("br2", 32'h14, 32'h0, 1'b0);
        check_req("br2", 1'b1, 32'h100);
        step();
        check_out("br3", 32'h104, 32'hA5A5_0100, 1'b1);

        // branches in DROP: newest target 0x300 wins
        drive(1'b0, 1'b0, 1'b1, 32'h200);
        step();
        drive(1'b0, 1'b0, 1'b1, 32'h300);
        step();
        check_out("dr1", 32'h104, 32'h0, 1'b0);
        check_req("dr1", 1'b1, 32'h104);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_req("dr2", 1'b1, 32'h300);
        check_out("dr2", 32'h104, 32'h0, 1'b0);

        // park 0x300 under stall, then branch out of HOLD
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check_req("hb0", 1'b0, 32'h304);
        drive(1'b0, 1'b1, 1'b1, 32'h400);
        step();
        check_out("hb1", 32'h104, 32'h0, 1'b0);
        check_req("hb1", 1'b1, 32'h400);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_out("hb2", 32'h404, 32'hA5A5_0400, 1'b1);

        // async reset mid-wait
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_out("mw", 32'h404, 32'h0, 1'b0);
        rst_i = 1'b0;
        #1;
        check_out("arst", 32'h0, 32'h0, 1'b0);
        check("arst.req", {31'h0, imem_req_o}, 32'h0);
        step();
        rst_i = 1'b1;
        #1;
        check_req("arel", 1'b1, 32'h0);

        // wrap at 0xFFFF_FFFC
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        check_req("wr0", 1'b1, 32'hFFFF_FFFC);
        check_out("wr0", 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_out("wr1", 32'h0, 32'h5A5A_FFFC, 1'b1);
        check_req("wr1", 1'b1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
